// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-stage MIPS pipeline: load-kind encoding used by EX, MEM and WB.
package cpu_pkg;

    typedef enum logic [2:0] {
        LD_NONE = 3'd0,
        LD_LB   = 3'd1,
        LD_LBU  = 3'd2,
        LD_LH   = 3'd3,
        LD_LHU  = 3'd4,
        LD_LW   = 3'd5,
        LD_LWL  = 3'd6,
        LD_LWR  = 3'd7
    } ld_op_t;

endpackage

// File: rtl/load_align.sv
// Load data alignment: byte/halfword select with extension, LWL/LWR merge with old rt.
module load_align
    import cpu_pkg::*;
(
    input  ld_op_t      ld_op,
    input  logic [1:0]  off,
    input  logic [31:0] m,
    input  logic [31:0] rt,
    input  logic [31:0] alu_result,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = m[7:0];
        unique case (off)
            2'd0: byte_sel = m[7:0];
            2'd1: byte_sel = m[15:8];
            2'd2: byte_sel = m[23:16];
            2'd3: byte_sel = m[31:24];
            default: byte_sel = m[7:0];
        endcase
        // off[0] ignored: misaligned halfwords are trapped upstream
        half_sel = off[1] ? m[31:16] : m[15:0];
    end

    always_comb begin
        result = alu_result;
        unique case (ld_op)
            LD_NONE: result = alu_result;
            LD_LB:   result = {{24{byte_sel[7]}}, byte_sel};
            LD_LBU:  result = {24'd0, byte_sel};
            LD_LH:   result = {{16{half_sel[15]}}, half_sel};
            LD_LHU:  result = {16'd0, half_sel};
            LD_LW:   result = m;
            LD_LWL: begin
                unique case (off)
                    2'd0: result = {m[7:0], rt[23:0]};
                    2'd1: result = {m[15:0], rt[15:0]};
                    2'd2: result = {m[23:0], rt[7:0]};
                    default: result = m;
                endcase
            end
            LD_LWR: begin
                unique case (off)
                    2'd0: result = m;
                    2'd1: result = {rt[31:24], m[31:8]};
                    2'd2: result = {rt[31:16], m[31:16]};
                    default: result = {rt[31:8], m[31:24]};
                endcase
            end
            default: result = alu_result;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// WB stage of the 5-stage MIPS pipeline: stage register, load alignment, RF write, forwarding.
// Define WB_DEBUG_EN to add the debug trace ports and the retired-instruction counter.
module writeback_stage
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        ms_to_ws_valid,
    output logic        ws_allowin,
    input  logic [31:0] ms_pc,
    input  logic [31:0] ms_alu_result,
    input  logic [31:0] ms_rt_value,
    input  logic [4:0]  ms_dest,
    input  logic        ms_rf_we,
    input  logic [2:0]  ms_load_op,
    input  logic [31:0] data_sram_rdata,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [4:0]  ws_fwd_dest,
    output logic [31:0] ws_fwd_data
`ifdef WB_DEBUG_EN
    ,
    output logic [31:0] debug_wb_pc,
    output logic [3:0]  debug_wb_rf_wen,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata,
    output logic [31:0] ws_retired_cnt
`endif
);

    logic        ws_valid;
    logic        ws_ready_go;
    logic [31:0] ws_pc;
    logic [31:0] ws_alu_result;
    logic [31:0] ws_rt_value;
    logic [4:0]  ws_dest;
    logic        ws_rf_we;
    ld_op_t      ws_load_op;
    logic [31:0] ws_result;

    assign ws_ready_go = 1'b1;
    assign ws_allowin  = !ws_valid || ws_ready_go;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ws_valid <= 1'b0;
        end else if (ws_allowin) begin
            ws_valid <= ms_to_ws_valid;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ws_pc         <= '0;
            ws_alu_result <= '0;
            ws_rt_value   <= '0;
            ws_dest       <= '0;
            ws_rf_we      <= 1'b0;
            ws_load_op    <= LD_NONE;
        end else if (ms_to_ws_valid && ws_allowin) begin
            ws_pc         <= ms_pc;
            ws_alu_result <= ms_alu_result;
            ws_rt_value   <= ms_rt_value;
            ws_dest       <= ms_dest;
            ws_rf_we      <= ms_rf_we;
            ws_load_op    <= ld_op_t'(ms_load_op);
        end
    end

    // SRAM read data arrives in this cycle and is consumed combinationally
    load_align u_load_align (
        .ld_op      (ws_load_op),
        .off        (ws_alu_result[1:0]),
        .m          (data_sram_rdata),
        .rt         (ws_rt_value),
        .alu_result (ws_alu_result),
        .result     (ws_result)
    );

    assign rf_we       = ws_valid && ws_rf_we && (ws_dest != 5'd0);
    assign rf_waddr    = ws_dest;
    assign rf_wdata    = ws_result;
    assign ws_fwd_dest = rf_we ? ws_dest : 5'd0;
    assign ws_fwd_data = rf_wdata;

`ifdef WB_DEBUG_EN
    assign debug_wb_pc       = ws_pc;
    assign debug_wb_rf_wen   = {4{rf_we}};
    assign debug_wb_rf_wnum  = ws_dest;
    assign debug_wb_rf_wdata = rf_wdata;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ws_retired_cnt <= '0;
        end else if (ws_valid) begin
            ws_retired_cnt <= ws_retired_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: doc/writeback_stage.md
# writeback_stage

Fifth pipeline stage of the 5-stage MIPS CPU, directly downstream of `memory_stage`. Latches the instruction leaving MEM and receives the synchronous data-SRAM read data one cycle after MEM issued the request. Performs load byte/halfword selection, extension and LWL/LWR merge, then writes the register file. Also drives the WB forwarding bus and, when enabled, the debug trace ports and a retired-instruction counter.

## Interface

Parameters: none.

Ports:
- `clk`  in  1  sole clock, rising edge
- `resetn`  in  1  asynchronous, active-low reset
- `ms_to_ws_valid`  in  1  MEM holds a valid instruction for WB
- `ws_allowin`  out  1  WB accepts an instruction this cycle
- `ms_pc`  in  32  PC of the incoming instruction
- `ms_alu_result`  in  32  ALU result; for loads, the data address
- `ms_rt_value`  in  32  old rt value, used for the LWL/LWR merge
- `ms_dest`  in  5  destination register number
- `ms_rf_we`  in  1  instruction writes the register file
- `ms_load_op`  in  3  load kind, `ld_op_t` encoding
- `data_sram_rdata`  in  32  SRAM read data, valid in the cycle the load is in WB
- `rf_we`  out  1  register-file write enable
- `rf_waddr`  out  5  register-file write address
- `rf_wdata`  out  32  register-file write data
- `ws_fwd_dest`  out  5  forwarding destination; 0 when not writing
- `ws_fwd_data`  out  32  forwarding data, equal to `rf_wdata`
- `debug_wb_pc`, `debug_wb_rf_wen[3:0]`, `debug_wb_rf_wnum[4:0]`, `debug_wb_rf_wdata[31:0]`, `ws_retired_cnt[31:0]`  out  present only with `WB_DEBUG_EN`

## Operation

- Stage register: `ws_valid`, `ws_pc`, `ws_alu_result`, `ws_rt_value`, `ws_dest`, `ws_rf_we`, `ws_load_op`.
- `ws_ready_go` is constant 1. `ws_allowin = !ws_valid || ws_ready_go`.
- On each rising edge with `ws_allowin`: `ws_valid <= ms_to_ws_valid`.
- Payload registers load only when `ms_to_ws_valid && ws_allowin`; otherwise they hold.
- Byte offset `off = ws_alu_result[1:0]`. Let `m = data_sram_rdata`, `rt = ws_rt_value`.
- LD_NONE: result is `ws_alu_result`.
- LB / LBU: byte `m[8*off+7 : 8*off]`, sign- or zero-extended to 32 bits.
- LH / LHU: halfword `m[16*off[1]+15 : 16*off[1]]`, sign- or zero-extended. Unaligned addresses are not checked here; `off[0]` is ignored.
- LW: result is `m`.
- LWL, by `off`: 0 → `{m[7:0], rt[23:0]}`; 1 → `{m[15:0], rt[15:0]}`; 2 → `{m[23:0], rt[7:0]}`; 3 → `m`.
- LWR, by `off`: 0 → `m`; 1 → `{rt[31:24], m[31:8]}`; 2 → `{rt[31:16], m[31:16]}`; 3 → `{rt[31:8], m[31:24]}`.
- Register-file outputs: `rf_we = ws_valid && ws_rf_we && (ws_dest != 0)`, `rf_waddr = ws_dest`, `rf_wdata` = the result above.
- Forwarding: `ws_fwd_dest = rf_we ? ws_dest : 0`; `ws_fwd_data = rf_wdata`.

## Timing

- Latency: an instruction accepted at edge N drives `rf_*` during cycle N..N+1 and is committed at edge N+1.
- `data_sram_rdata` is used combinationally in that same cycle and is never registered in WB.
- Reset (asynchronous, on `resetn` low):
  - `ws_valid = 0`, so `rf_we = 0`, `ws_fwd_dest = 0`, `ws_allowin = 1`.
  - All payload registers clear to 0, so `rf_waddr = 0` and `rf_wdata = 0`.
  - `ws_retired_cnt = 0`.
- Reset asserted mid-operation drops the in-flight instruction; no write occurs.
- Back-to-back instructions are accepted every cycle; WB never stalls.
- A write to `$0` is suppressed, and `ws_fwd_dest` stays 0 for it.

## Configuration

- `WB_DEBUG_EN` defined:
  - `debug_wb_pc = ws_pc`, `debug_wb_rf_wen = {4{rf_we}}`, `debug_wb_rf_wnum = ws_dest`, `debug_wb_rf_wdata = rf_wdata`.
  - `ws_retired_cnt` increments by 1 on every edge where `ws_valid` is 1; it wraps from 0xFFFFFFFF to 0.
- `WB_DEBUG_EN` undefined: these ports and the counter do not exist. Functional behaviour is otherwise identical.

## Structure

- Shared package `cpu_pkg`: the `ld_op_t` encoding `LD_NONE=0`, `LD_LB=1`, `LD_LBU=2`, `LD_LH=3`, `LD_LHU=4`, `LD_LW=5`, `LD_LWL=6`, `LD_LWR=7`. The MEM and EX stages use the same package.
- One combinational sub-module, `load_align`, with inputs `ld_op`, `off`, `m`, `rt`, `alu_result` and output `result`. Stage register, handshake and debug logic stay in `writeback_stage`.

## Test plan

- Reset: hold `resetn=0` with `ms_to_ws_valid=1` → `rf_we=0`, `ws_allowin=1`, `ws_retired_cnt=0`.
- ALU write: `ms_load_op=LD_NONE`, `ms_dest=5`, `ms_alu_result=0x12345678` → next cycle `rf_we=1`, `rf_waddr=5`, `rf_wdata=0x12345678`, `ws_fwd_dest=5`.
- Sub-word loads with `m=0x80FF7F01`:
  - LB `off=1` → `0x0000007F`
  - LB `off=2` → `0xFFFFFFFF`
  - LBU `off=3` → `0x00000080`
  - LH `off=2` → `0xFFFF80FF`
  - LHU `off=0` → `0x00007F01`
- LWL/LWR with `m=0xAABBCCDD`, `rt=0x11223344`:
  - LWL `off=1` → `0xCCDD3344`
  - LWR `off=2` → `0x1122AABB`
- `$0` and bubble:
  - `ms_dest=0` with `ms_rf_we=1` → `rf_we=0`, `ws_fwd_dest=0`.
  - `ms_to_ws_valid=0` for one cycle → `rf_we=0` that cycle and the counter does not increment.
- Debug (`WB_DEBUG_EN` defined): 10 consecutive valid instructions → `ws_retired_cnt=10` and `debug_wb_rf_wen=0xF` on each write. With the counter preloaded near 0xFFFFFFFF via a hierarchical force, it wraps to 0.
